// File: rtl/raspi_link_slave.sv
// FPGA end of the 9-bit Raspberry Pi parallel link: synchronizes the Pi strobe and bus,
// tracks the selected endpoint and bridges Pi writes/reads to an RX and a TX FIFO.
module raspi_link_slave #(
    parameter int unsigned RX_ABITS = 4,
    parameter int unsigned TX_ABITS = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [8:0] raspi_dat_in,
    output logic [8:0] raspi_dat_out,
    output logic       raspi_dat_oe,
    input  logic       raspi_dir,
    input  logic       raspi_clk,
    output logic       recv_valid,
    input  logic       recv_ready,
    output logic [7:0] recv_ep,
    output logic [7:0] recv_data,
    input  logic       send_valid,
    output logic       send_ready,
    input  logic [7:0] send_data,
    output logic [7:0] ep_sel,
    output logic       rx_overflow
);
    localparam int unsigned RX_DEPTH = 1 << RX_ABITS;
    localparam int unsigned TX_DEPTH = 1 << TX_ABITS;
    localparam int unsigned RX_PW    = RX_ABITS + 1;
    localparam int unsigned TX_PW    = TX_ABITS + 1;

    logic [1:0]       sclk_q;
    logic             sclk_prev_q;
    logic [1:0]       sdir_q;
    logic [8:0]       sdat0_q, sdat1_q;
    logic             dir_prev_q;

    logic [7:0]       ep_q, ep_d;
    logic             ovf_q, ovf_d;
    logic             oe_q, oe_d;
    logic [8:0]       dat_out_q, dat_out_d;
    logic [RX_PW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [TX_PW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;

    logic [15:0]      rx_mem_q [RX_DEPTH];
    logic [7:0]       tx_mem_q [TX_DEPTH];

    logic strobe, dir_s, wr_data, rx_empty, rx_full, tx_empty, tx_full;
    logic rx_push, rx_pop, tx_push, tx_pop;

    assign strobe   = sclk_q[1] & ~sclk_prev_q;
    assign dir_s    = sdir_q[1];

    assign rx_empty = (rx_wr_q == rx_rd_q);
    assign rx_full  = (rx_wr_q[RX_ABITS-1:0] == rx_rd_q[RX_ABITS-1:0]) &&
                      (rx_wr_q[RX_ABITS] != rx_rd_q[RX_ABITS]);
    assign tx_empty = (tx_wr_q == tx_rd_q);
    assign tx_full  = (tx_wr_q[TX_ABITS-1:0] == tx_rd_q[TX_ABITS-1:0]) &&
                      (tx_wr_q[TX_ABITS] != tx_rd_q[TX_ABITS]);

    // A pop in the same cycle frees the slot, so a full FIFO can still accept a push.
    assign wr_data  = strobe & dir_s & ~sdat1_q[8];
    assign rx_pop   = ~rx_empty & recv_ready;
    assign rx_push  = wr_data & (~rx_full | rx_pop);
    assign tx_pop   = strobe & ~dir_s & ~tx_empty;
    assign tx_push  = send_valid & send_ready;

    assign recv_valid    = ~rx_empty;
    assign recv_ep       = rx_mem_q[rx_rd_q[RX_ABITS-1:0]][15:8];
    assign recv_data     = rx_mem_q[rx_rd_q[RX_ABITS-1:0]][7:0];
    assign send_ready    = ~tx_full | tx_pop;
    assign ep_sel        = ep_q;
    assign rx_overflow   = ovf_q;
    assign raspi_dat_oe  = oe_q;
    assign raspi_dat_out = dat_out_q;

    // Next-state for link registers and FIFO pointers.
    always_comb begin
        ep_d      = ep_q;
        ovf_d     = ovf_q;
        oe_d      = oe_q;
        rx_wr_d   = rx_wr_q;
        rx_rd_d   = rx_rd_q;
        tx_wr_d   = tx_wr_q;
        tx_rd_d   = tx_rd_q;
        dat_out_d = tx_empty ? 9'h1ff : {1'b0, tx_mem_q[tx_rd_q[TX_ABITS-1:0]]};

        // The idle word 9'h1ff carries 8'hff in its low byte, which is the "none" endpoint.
        if (strobe && dir_s && sdat1_q[8]) ep_d = sdat1_q[7:0];
        if (wr_data && !rx_push) ovf_d = 1'b1;

        if (dir_s)           oe_d = 1'b0;
        else if (dir_prev_q) oe_d = 1'b1;

        if (rx_push) rx_wr_d = rx_wr_q + RX_PW'(1);
        if (rx_pop)  rx_rd_d = rx_rd_q + RX_PW'(1);
        if (tx_push) tx_wr_d = tx_wr_q + TX_PW'(1);
        if (tx_pop)  tx_rd_d = tx_rd_q + TX_PW'(1);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sclk_q      <= '0;
            sclk_prev_q <= 1'b0;
            sdir_q      <= '0;
            sdat0_q     <= '0;
            sdat1_q     <= '0;
            dir_prev_q  <= 1'b0;
            ep_q        <= 8'hff;
            ovf_q       <= 1'b0;
            oe_q        <= 1'b0;
            dat_out_q   <= 9'h1ff;
            rx_wr_q     <= '0;
            rx_rd_q     <= '0;
            tx_wr_q     <= '0;
            tx_rd_q     <= '0;
        end else begin
            sclk_q      <= {sclk_q[0], raspi_clk};
            sclk_prev_q <= sclk_q[1];
            sdir_q      <= {sdir_q[0], raspi_dir};
            sdat0_q     <= raspi_dat_in;
            sdat1_q     <= sdat0_q;
            dir_prev_q  <= dir_s;
            ep_q        <= ep_d;
            ovf_q       <= ovf_d;
            oe_q        <= oe_d;
            dat_out_q   <= dat_out_d;
            rx_wr_q     <= rx_wr_d;
            rx_rd_q     <= rx_rd_d;
            tx_wr_q     <= tx_wr_d;
            tx_rd_q     <= tx_rd_d;
        end
    end

    // FIFO storage needs no reset; pointers define validity.
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem_q[rx_wr_q[RX_ABITS-1:0]] <= {ep_q, sdat1_q[7:0]};
        if (tx_push) tx_mem_q[tx_wr_q[TX_ABITS-1:0]] <= send_data;
    end

endmodule

// File: tb/tb_raspi_link_slave.sv
// Directed/randomized bench for raspi_link_slave: drives the Pi pin protocol and fabric
// streams, comparing everything against queue-based models of the link.
module tb_raspi_link_slave;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [8:0] raspi_dat_in = '0;
    logic [8:0] raspi_dat_out;
    logic       raspi_dat_oe;
    logic       raspi_dir = 1'b1;
    logic       raspi_clk = 1'b0;
    logic       recv_valid;
    logic       recv_ready = 1'b0;
    logic [7:0] recv_ep;
    logic [7:0] recv_data;
    logic       send_valid = 1'b0;
    logic       send_ready;
    logic [7:0] send_data = '0;
    logic [7:0] ep_sel;
    logic       rx_overflow;

    raspi_link_slave #(.RX_ABITS(4), .TX_ABITS(4)) dut (
        .clk(clk), .resetn(resetn),
        .raspi_dat_in(raspi_dat_in), .raspi_dat_out(raspi_dat_out), .raspi_dat_oe(raspi_dat_oe),
        .raspi_dir(raspi_dir), .raspi_clk(raspi_clk),
        .recv_valid(recv_valid), .recv_ready(recv_ready), .recv_ep(recv_ep), .recv_data(recv_data),
        .send_valid(send_valid), .send_ready(send_ready), .send_data(send_data),
        .ep_sel(ep_sel), .rx_overflow(rx_overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] rx_q[$];
    logic [7:0]  tx_q[$];
    logic [7:0]  m_ep  = 8'hff;
    logic        m_ovf = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pi write: data set up, strobe raised, held, then released.
    task automatic pi_write(input logic [8:0] w);
        logic fast;
        int   lat;
        fast = (w[8] == 1'b0) && (rx_q.size() == 0);
        @(negedge clk);
        raspi_dir    = 1'b1;
        raspi_dat_in = w;
        repeat (3) @(negedge clk);
        raspi_clk = 1'b1;
        lat = 0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            if (recv_valid && lat == 0) lat = k;
        end
        if (w[8])                 m_ep = w[7:0];
        else if (rx_q.size() < 16) rx_q.push_back({m_ep, w[7:0]});
        else                       m_ovf = 1'b1;
        if (fast) check("rx_latency", 32'(lat != 0), 1);
        @(negedge clk);
        raspi_clk = 1'b0;
        repeat (4) @(negedge clk);
        check("oe_in_write", 32'(raspi_dat_oe), 0);
        check("ep_sel", 32'(ep_sel), 32'(m_ep));
        check("rx_overflow", 32'(rx_overflow), 32'(m_ovf));
    endtask

    // Pi read: turn the bus around, sample the word, then strobe to pop.
    task automatic pi_read(input string tag);
        logic [8:0] e;
        @(negedge clk);
        raspi_dir = 1'b0;
        repeat (4) @(negedge clk);
        check("oe_in_read", 32'(raspi_dat_oe), 1);
        e = (tx_q.size() != 0) ? {1'b0, tx_q[0]} : 9'h1ff;
        check(tag, 32'(raspi_dat_out), 32'(e));
        if (tx_q.size() != 0) tx_q.delete(0);
        raspi_clk = 1'b1;
        repeat (4) @(negedge clk);
        raspi_clk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic pop_recv(output logic [7:0] a);
        int          waited;
        logic [15:0] e;
        waited = 0;
        @(negedge clk);
        while (!recv_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("recv_valid", 32'(recv_valid), 1);
        e = (rx_q.size() != 0) ? rx_q[0] : 16'h0;
        if (rx_q.size() != 0) rx_q.delete(0);
        check("recv_word", 32'({recv_ep, recv_data}), 32'(e));
        a = e[7:0];
        recv_ready = 1'b1;
        @(posedge clk); #1;
        recv_ready = 1'b0;
    endtask

    task automatic push_send(input logic [7:0] b);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!send_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("send_ready", 32'(send_ready), 1);
        send_valid = 1'b1;
        send_data  = b;
        @(posedge clk); #1;
        send_valid = 1'b0;
        if (waited < 20) tx_q.push_back(b);
    endtask

    // Read from a full TX while the producer offers a byte in the same strobe window.
    task automatic pi_read_push(input logic [7:0] b);
        logic acc;
        @(negedge clk);
        raspi_dir = 1'b0;
        repeat (4) @(negedge clk);
        check("full_read", 32'(raspi_dat_out), 32'({1'b0, tx_q[0]}));
        check("full_not_ready", 32'(send_ready), 0);
        send_valid = 1'b1;
        send_data  = b;
        raspi_clk  = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (!acc && send_ready) begin
                acc = 1'b1;
                @(posedge clk); #1;
                send_valid = 1'b0;
            end
        end
        send_valid = 1'b0;
        check("full_push_accept", 32'(acc), 1);
        tx_q.delete(0);
        if (acc) tx_q.push_back(b);
        raspi_clk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    function automatic logic [7:0] loop_fn(input logic [7:0] a);
        int unsigned v;
        v = ((32'(a) << 5) + 32'(a)) ^ 32'd7;
        return 8'(v & 32'hff);
    endfunction

    initial begin
        logic [7:0]  b;
        int unsigned n, kind, ndata;

        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("rst_ep_sel", 32'(ep_sel), 32'hff);
        check("rst_recv_valid", 32'(recv_valid), 0);
        check("rst_send_ready", 32'(send_ready), 1);
        check("rst_oe", 32'(raspi_dat_oe), 0);
        check("rst_overflow", 32'(rx_overflow), 0);

        for (int i = 0; i < 8; i++) begin
            pi_write(9'h1ff);
            check("idle_no_recv", 32'(recv_valid), 0);
        end

        // Endpoint 0, then 64 bytes looped back in chunks that fit both FIFOs.
        pi_write(9'h100);
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 16; i++) pi_write({1'b0, 8'(64 + c * 16 + i)});
            for (int i = 0; i < 16; i++) begin
                pop_recv(b);
                push_send(loop_fn(b));
            end
            for (int i = 0; i < 16; i++) pi_read("loop_read");
        end

        pi_read("empty_read");
        push_send(8'h5a);
        pi_read("after_push_read");
        pi_read("empty_again");

        for (int i = 0; i < 17; i++) pi_write({1'b0, 8'($urandom)});
        check("ovf_set", 32'(rx_overflow), 1);
        repeat (5) @(negedge clk);
        check("recv_hold", 32'({recv_ep, recv_data}), 32'(rx_q[0]));
        for (int i = 0; i < 16; i++) pop_recv(b);
        @(negedge clk);
        check("ovf_drained", 32'(recv_valid), 0);

        for (int r = 0; r < 3; r++) begin
            ndata = 0;
            for (int i = 0; i < 14; i++) begin
                kind = $urandom_range(0, 4);
                if (kind == 0)       pi_write({1'b1, 8'($urandom_range(0, 254))});
                else if (kind == 1)  pi_write(9'h1ff);
                else if (ndata < 12) begin
                    pi_write({1'b0, 8'($urandom)});
                    ndata++;
                end
            end
            while (rx_q.size() > 0) pop_recv(b);
            @(negedge clk);
            check("rand_drained", 32'(recv_valid), 0);
            n = $urandom_range(1, 15);
            for (int i = 0; i < int'(n); i++) push_send(8'($urandom));
            for (int i = 0; i <= int'(n); i++) pi_read("rand_read");
        end

        for (int i = 0; i < 16; i++) push_send(8'($urandom));
        @(negedge clk);
        check("tx_full_ready", 32'(send_ready), 0);
        pi_read_push(8'($urandom));
        @(negedge clk);
        check("tx_still_full", 32'(send_ready), 0);
        for (int i = 0; i < 17; i++) pi_read("full_drain");

        // Reset in the middle of a read with both FIFOs holding data.
        pi_write(9'h103);
        for (int i = 0; i < 3; i++) pi_write({1'b0, 8'($urandom)});
        for (int i = 0; i < 4; i++) push_send(8'($urandom));
        @(negedge clk);
        raspi_dir = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_reset_oe", 32'(raspi_dat_oe), 1);
        resetn = 1'b0;
        @(negedge clk);
        check("in_reset_oe", 32'(raspi_dat_oe), 0);
        raspi_dir = 1'b1;
        @(negedge clk);
        resetn = 1'b1;
        rx_q.delete();
        tx_q.delete();
        m_ep  = 8'hff;
        m_ovf = 1'b0;
        repeat (5) @(negedge clk);
        check("post_reset_oe", 32'(raspi_dat_oe), 0);
        check("post_reset_recv", 32'(recv_valid), 0);
        check("post_reset_send", 32'(send_ready), 1);
        check("post_reset_ep", 32'(ep_sel), 32'hff);
        check("post_reset_ovf", 32'(rx_overflow), 0);
        pi_write({1'b0, 8'($urandom)});
        pop_recv(b);
        pi_read("post_reset_read");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
